// File: rtl/isa_pkg.sv
// Shared ISA definitions for the issue stage: opcodes, scheduler states and
// the intra-pair hazard decode used by dual_issue_scheduler.
package isa_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {IDLE, PAIR, SOLO_B} sched_state_t;

    function automatic logic writes_rd(input logic [31:0] instr);
        return (instr[6:0] != OP_STORE) && (instr[6:0] != OP_BRANCH) && (instr[11:7] != 5'd0);
    endfunction

    function automatic logic reads_rs1(input logic [31:0] instr);
        return (instr[6:0] != OP_LUI) && (instr[6:0] != OP_AUIPC) && (instr[6:0] != OP_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] instr);
        return (instr[6:0] == OP_REG) || (instr[6:0] == OP_STORE) || (instr[6:0] == OP_BRANCH);
    endfunction

    function automatic logic is_mem(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

    // True when the younger instruction b cannot issue alongside the older a.
    function automatic logic pair_hazard(input logic [31:0] a, input logic [31:0] b);
        logic raw, waw, mem, ctl;
        raw = writes_rd(a) && ((reads_rs1(b) && (b[19:15] == a[11:7])) ||
                               (reads_rs2(b) && (b[24:20] == a[11:7])));
        waw = writes_rd(a) && writes_rd(b) && (a[11:7] == b[11:7]);
        mem = is_mem(a[6:0]) && is_mem(b[6:0]);
        ctl = (a[6:0] == OP_BRANCH) || (a[6:0] == OP_JAL) || (a[6:0] == OP_JALR);
        return raw || waw || mem || ctl;
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-pair and dual-lane issue bus between the front end, the scheduler
// and the execute lanes.
interface dual_issue_scheduler_if;
    import isa_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instrA;
    logic [31:0]     in_instrB;
    logic            in_b_valid;
    logic [XLEN-1:0] in_pc;

    logic            issue_ready;
    logic            issue_validA;
    logic            issue_validB;
    logic [31:0]     issue_instrA;
    logic [31:0]     issue_instrB;
    logic [XLEN-1:0] issue_immA;
    logic [XLEN-1:0] issue_immB;
    logic [XLEN-1:0] issue_pcA;
    logic [XLEN-1:0] issue_pcB;

    modport master (
        output in_valid, in_instrA, in_instrB, in_b_valid, in_pc, issue_ready,
        input  in_ready, issue_validA, issue_validB, issue_instrA, issue_instrB,
               issue_immA, issue_immB, issue_pcA, issue_pcB
    );

    modport slave (
        input  in_valid, in_instrA, in_instrB, in_b_valid, in_pc, issue_ready,
        output in_ready, issue_validA, issue_validB, issue_instrA, issue_instrB,
               issue_immA, issue_immB, issue_pcA, issue_pcB
    );

endinterface

// File: rtl/immediate_gen.sv
// Dual-lane RV64 immediate generator: sign-extended immediate for each lane's
// instruction, zero for formats without an immediate (R-type).
module immediate_gen
    import isa_pkg::*;
(
    input  logic [31:0]     instrA,
    input  logic [31:0]     instrB,
    output logic [XLEN-1:0] immA,
    output logic [XLEN-1:0] immB
);

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i);
        logic [XLEN-1:0] imm;
        case (i[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm = {{52{i[31]}}, i[31:20]};
            OP_STORE:                 imm = {{52{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:                imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {{32{i[31]}}, i[31:12], 12'b0};
            OP_JAL:                   imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:                  imm = '0;
        endcase
        return imm;
    endfunction

    assign immA = gen_imm(instrA);
    assign immB = gen_imm(instrB);

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue-stage scheduler: buffers one fetched pair, dual-issues it when the
// pair is hazard-free, otherwise splits it so the older instruction goes first.
module dual_issue_scheduler
    import isa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    output logic [15:0]          split_count,
    dual_issue_scheduler_if.slave bus
);

    sched_state_t    state, state_next;
    logic [31:0]     buf_a, buf_b;
    logic [XLEN-1:0] buf_pc, pc_b;
    logic            buf_bv;
    logic            split, issue, capture;

    assign pc_b    = buf_pc + 64'd4;
    assign split   = (state == PAIR) && buf_bv && pair_hazard(buf_a, buf_b);
    assign issue   = bus.issue_ready && bus.issue_validA;
    assign capture = bus.in_valid && bus.in_ready;

    // A new pair may enter only in a cycle where the buffer is fully drained.
    assign bus.in_ready = !rst && !flush &&
                          ((state == IDLE) ||
                           ((state == PAIR) && !split && bus.issue_ready) ||
                           ((state == SOLO_B) && bus.issue_ready));

    assign bus.issue_validA = (state != IDLE);
    assign bus.issue_validB = (state == PAIR) && !split && buf_bv;
    assign bus.issue_instrA = (state == SOLO_B) ? buf_b : buf_a;
    assign bus.issue_pcA    = (state == SOLO_B) ? pc_b : buf_pc;
    assign bus.issue_instrB = buf_b;
    assign bus.issue_pcB    = pc_b;

    immediate_gen u_immediate_gen (
        .instrA (bus.issue_instrA),
        .instrB (bus.issue_instrB),
        .immA   (bus.issue_immA),
        .immB   (bus.issue_immB)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (capture) state_next = PAIR;
                PAIR:    if (issue) state_next = split ? SOLO_B : (capture ? PAIR : IDLE);
                SOLO_B:  if (issue) state_next = capture ? PAIR : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a  <= '0;
            buf_b  <= '0;
            buf_pc <= '0;
            buf_bv <= 1'b0;
        end else if (capture) begin
            buf_a  <= bus.in_instrA;
            buf_b  <= bus.in_instrB;
            buf_pc <= bus.in_pc;
            buf_bv <= bus.in_b_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     split_count <= '0;
        else if (issue && split && split_count != 16'hFFFF) split_count <= split_count + 16'd1;
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: table of pairs with a
// scoreboard of expected issue beats, plus stall, flush and reset sequences.
module tb_dual_issue_scheduler;
    import isa_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bv;
        logic [63:0] pc;
        logic        split;
        logic [63:0] imm_a;
        logic [63:0] imm_b;
    } vec_t;

    typedef struct {
        logic        vb;
        logic [31:0] ia;
        logic [63:0] pa;
        logic [63:0] ma;
        logic [31:0] ib;
        logic [63:0] pb;
        logic [63:0] mb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] split_count;

    dual_issue_scheduler_if bus();

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .split_count (split_count),
        .bus         (bus)
    );

    always #10 clk = ~clk;

    exp_t sb[$];
    vec_t vecs[11];
    int   tests = 0;
    int   fails = 0;
    int   exp_splits = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Each issue handshake consumes the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!rst && bus.issue_validA && bus.issue_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("instrA", {32'h0, bus.issue_instrA}, {32'h0, e.ia});
                checkOutput("pcA", bus.issue_pcA, e.pa);
                checkOutput("immA", bus.issue_immA, e.ma);
                checkOutput("validB", {63'h0, bus.issue_validB}, {63'h0, e.vb});
                if (e.vb) begin
                    checkOutput("instrB", {32'h0, bus.issue_instrB}, {32'h0, e.ib});
                    checkOutput("pcB", bus.issue_pcB, e.pb);
                    checkOutput("immB", bus.issue_immB, e.mb);
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            #1;
            bus.in_valid   = 1'b1;
            bus.in_instrA  = v.a;
            bus.in_instrB  = v.b;
            bus.in_b_valid = v.bv;
            bus.in_pc      = v.pc;
            #1;
            if (bus.in_ready) begin
                if (v.split) begin
                    sb.push_back('{1'b0, v.a, v.pc, v.imm_a, 32'h0, 64'h0, 64'h0});
                    sb.push_back('{1'b0, v.b, v.pc + 64'd4, v.imm_b, 32'h0, 64'h0, 64'h0});
                    exp_splits++;
                end else begin
                    sb.push_back('{v.bv, v.a, v.pc, v.imm_a, v.b, v.pc + 64'd4, v.imm_b});
                end
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 1'b0;
        for (int k = 0; k < 40 && !drained; k++) begin
            @(negedge clk);
            #4;
            if (sb.size() == 0) drained = 1'b1;
        end
        if (!drained) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, total;

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instrA = '0;
        bus.in_instrB = '0;
        bus.in_b_valid = 1'b0;
        bus.in_pc = '0;
        bus.issue_ready = 1'b1;

        vecs[0]  = '{32'hFFF10093, 32'h00430293, 1'b1, 64'h1000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4};
        vecs[1]  = '{32'hFFF10093, 32'h004081B3, 1'b1, 64'h1000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[2]  = '{32'hFFF10013, 32'h004001B3, 1'b1, 64'h1100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3]  = '{32'h00412083, 32'h00112023, 1'b1, 64'h1200, 1'b1, 64'h4, 64'h0};
        vecs[4]  = '{32'h00430293, 32'h004081B3, 1'b0, 64'h2000, 1'b0, 64'h4, 64'h0};
        vecs[5]  = '{32'h00430293, 32'h123452B7, 1'b1, 64'h1300, 1'b1, 64'h4, 64'h12345000};
        vecs[6]  = '{32'h0080006F, 32'h00430293, 1'b1, 64'h1400, 1'b1, 64'h8, 64'h4};
        vecs[7]  = '{32'h00208863, 32'h00430293, 1'b1, 64'h1500, 1'b1, 64'h10, 64'h4};
        vecs[8]  = '{32'hFE112E23, 32'h00430293, 1'b1, 64'h1600, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4};
        vecs[9]  = '{32'h00000213, 32'h004081B3, 1'b1, 64'h1700, 1'b1, 64'h0, 64'h0};
        vecs[10] = '{32'hFFF10093, 32'h00008397, 1'b1, 64'h1800, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000};

        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_in_ready", {63'h0, bus.in_ready}, 64'd0);
        checkOutput("rst_validA", {63'h0, bus.issue_validA}, 64'd0);
        checkOutput("rst_validB", {63'h0, bus.issue_validB}, 64'd0);
        checkOutput("rst_split_count", {48'h0, split_count}, 64'd0);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {63'h0, bus.in_ready}, 64'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], w);
            waitDrain();
            checkOutput("split_count", {48'h0, split_count}, 64'(exp_splits));
        end

        // Back-to-back hazard-free pairs must be accepted every cycle.
        total = 0;
        applyStimulus(vecs[0], w);  total += w;
        applyStimulus(vecs[2], w);  total += w;
        applyStimulus(vecs[10], w); total += w;
        checkOutput("throughput_waits", 64'(total), 64'd0);
        waitDrain();

        // Split pair with the second beat stalled for three cycles.
        applyStimulus(vecs[3], w);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            bus.issue_ready = 1'b0;
            #1;
            checkOutput("stall_validA", {63'h0, bus.issue_validA}, 64'd1);
            checkOutput("stall_validB", {63'h0, bus.issue_validB}, 64'd0);
            checkOutput("stall_instrA", {32'h0, bus.issue_instrA}, 64'h00112023);
            checkOutput("stall_pcA", bus.issue_pcA, 64'h1204);
            checkOutput("stall_immA", bus.issue_immA, 64'h0);
            checkOutput("stall_in_ready", {63'h0, bus.in_ready}, 64'd0);
        end
        @(negedge clk);
        #1;
        bus.issue_ready = 1'b1;
        waitDrain();
        checkOutput("stall_split_count", {48'h0, split_count}, 64'(exp_splits));

        // Flush while the younger half of a split pair is pending.
        applyStimulus(vecs[1], w);
        @(negedge clk);
        @(negedge clk);
        #1;
        flush = 1'b1;
        bus.issue_ready = 1'b0;
        #1;
        checkOutput("flush_in_ready", {63'h0, bus.in_ready}, 64'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.issue_ready = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("post_flush_validA", {63'h0, bus.issue_validA}, 64'd0);
        checkOutput("post_flush_validB", {63'h0, bus.issue_validB}, 64'd0);
        checkOutput("post_flush_in_ready", {63'h0, bus.in_ready}, 64'd1);
        checkOutput("post_flush_split_count", {48'h0, split_count}, 64'(exp_splits));
        applyStimulus(vecs[0], w);
        waitDrain();

        // Asynchronous reset between edges while a pair is buffered.
        @(negedge clk);
        #1;
        bus.issue_ready = 1'b0;
        applyStimulus(vecs[0], w);
        @(negedge clk);
        #2;
        checkOutput("pre_reset_validA", {63'h0, bus.issue_validA}, 64'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_validA", {63'h0, bus.issue_validA}, 64'd0);
        checkOutput("async_rst_validB", {63'h0, bus.issue_validB}, 64'd0);
        checkOutput("async_rst_in_ready", {63'h0, bus.in_ready}, 64'd0);
        checkOutput("async_rst_split_count", {48'h0, split_count}, 64'd0);
        sb.delete();
        exp_splits = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.issue_ready = 1'b1;
        #1;
        checkOutput("ready_after_async_reset", {63'h0, bus.in_ready}, 64'd1);
        applyStimulus(vecs[1], w);
        waitDrain();
        checkOutput("final_split_count", {48'h0, split_count}, 64'(exp_splits));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
